// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: multi-cycle HI/LO unit for the EX stage.
// Executes mthi/mtlo immediately and mult/multu/madd/msub over MUL_CYCLES
// cycles, reporting Busy/Stall to the hazard unit and allowing a flush to
// abort an in-flight operation without touching HI/LO.
//
// Handshake: an op is offered when Start is high with a non-zero HiLoEnable.
// It is taken on the rising edge only while the unit is idle and Flush is low.
// While an op is in flight, Stall tells upstream to hold and re-present the op.
module hilo_muldiv_seq #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        HiLoEnable,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic              ReadReq,
    input  logic              Flush,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo,
    output logic              Busy,
    output logic              Stall,
    output logic              Done
);

    localparam int PW = 2 * DATA_W;
    localparam logic [3:0] COUNT_INIT = 4'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_MTLO  = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MULTU = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        count;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic              capture;
    logic              commit;
    logic              load_hi;
    logic              load_lo;

    logic [PW-1:0]     a_sx;
    logic [PW-1:0]     b_sx;
    logic [PW-1:0]     a_zx;
    logic [PW-1:0]     b_zx;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     prod_u;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     result;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and one-cycle control strobes for the datapath.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        load_hi    = 1'b0;
        load_lo    = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    case (HiLoEnable)
                        OP_MTLO: load_lo = 1'b1;
                        OP_MTHI: load_hi = 1'b1;
                        OP_MULT, OP_MADD, OP_MSUB, OP_MULTU: begin
                            capture    = 1'b1;
                            state_next = BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // Flush wins over commit, even on the last cycle.
                if (Flush) begin
                    state_next = IDLE;
                end else if (count == 4'd0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result of the captured op; products wrap to 2*DATA_W bits, so a
    // sign-extended multiply gives the two's-complement signed product.
    always_comb begin
        a_sx   = {{DATA_W{a_q[DATA_W-1]}}, a_q};
        b_sx   = {{DATA_W{b_q[DATA_W-1]}}, b_q};
        a_zx   = {{DATA_W{1'b0}}, a_q};
        b_zx   = {{DATA_W{1'b0}}, b_q};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;
        acc    = {Hi, Lo};
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MADD:  result = acc + prod_s;
            OP_MSUB:  result = acc - prod_s;
            OP_MULTU: result = prod_u;
            default:  result = acc;
        endcase
    end

    // HI/LO, captured operands, cycle counter and the Done pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Hi    <= '0;
            Lo    <= '0;
            Done  <= 1'b0;
            count <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            Done <= commit;
            if (load_lo) begin
                Lo <= OpA;
            end
            if (load_hi) begin
                Hi <= OpA;
            end
            if (capture) begin
                a_q   <= OpA;
                b_q   <= OpB;
                op_q  <= HiLoEnable;
                count <= COUNT_INIT;
            end else if (state == BUSY) begin
                count <= (Flush || count == 4'd0) ? 4'd0 : count - 4'd1;
            end
            if (commit) begin
                Hi <= result[PW-1:DATA_W];
                Lo <= result[DATA_W-1:0];
            end
        end
    end

    assign Busy  = (state == BUSY);
    assign Stall = Busy && (ReadReq || (Start && HiLoEnable != 3'd0));

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Bench for hilo_muldiv_seq: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a reference model.
module tb_hilo_muldiv_seq;

  localparam int W = 32;
  localparam int M = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         read_req = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, stall, done;

  // second instance: 16-bit, single-cycle latency
  logic         s_reset = 1'b1;
  logic         s_start = 1'b0;
  logic [2:0]   s_op = 3'd0;
  logic [15:0]  s_a = '0;
  logic [15:0]  s_b = '0;
  logic [15:0]  s_hi, s_lo;
  logic         s_busy, s_stall, s_done;

  hilo_muldiv_seq #(.DATA_W(W), .MUL_CYCLES(M)) u_dut (
    .Clk(clk), .Reset(reset), .Start(start), .HiLoEnable(op),
    .OpA(op_a), .OpB(op_b), .ReadReq(read_req), .Flush(flush),
    .Hi(hi), .Lo(lo), .Busy(busy), .Stall(stall), .Done(done)
  );

  hilo_muldiv_seq #(.DATA_W(16), .MUL_CYCLES(1)) u_dut1 (
    .Clk(clk), .Reset(s_reset), .Start(s_start), .HiLoEnable(s_op),
    .OpA(s_a), .OpB(s_b), .ReadReq(1'b0), .Flush(1'b0),
    .Hi(s_hi), .Lo(s_lo), .Busy(s_busy), .Stall(s_stall), .Done(s_done)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the architectural view: HI/LO, whether an op is in flight and
  // the edge number on which it is due to land.
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_inflight = 1'b0;
  logic         m_done = 1'b0;
  logic [2:0]   m_op;
  logic [W-1:0] m_a, m_b;
  longint       edge_n = 0;
  longint       m_due = 0;

  function automatic logic [63:0] model_result(input logic [2:0] code, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [63:0] acc);
    longint sa, sb;
    logic [63:0] ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    case (code)
      3'd3:    return ps;
      3'd4:    return acc + ps;
      3'd5:    return acc - ps;
      3'd6:    return pu;
      default: return acc;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [63:0] r;
    edge_n++;
    m_done = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_inflight = 1'b0;
    end else if (m_inflight) begin
      if (flush) begin
        m_inflight = 1'b0;
      end else if (edge_n == m_due) begin
        r = model_result(m_op, m_a, m_b, {m_hi, m_lo});
        m_hi = r[63:32];
        m_lo = r[31:0];
        m_inflight = 1'b0;
        m_done = 1'b1;
      end
    end else if (start && !flush) begin
      if (op == 3'd1) m_lo = op_a;
      else if (op == 3'd2) m_hi = op_a;
      else if (op >= 3'd3 && op <= 3'd6) begin
        m_op = op; m_a = op_a; m_b = op_b;
        m_due = edge_n + M;
        m_inflight = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_hi", 64'(hi), 64'(m_hi));
      check("model_lo", 64'(lo), 64'(m_lo));
      check("model_busy", 64'(busy), 64'(m_inflight));
      check("model_done", 64'(done), 64'(m_done));
      check("model_stall", 64'(stall),
            64'(m_inflight && (read_req || (start && op != 3'd0))));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 1'b0; op = 3'd0; read_req = 1'b0; flush = 1'b0;
  endtask

  // Offers one op for a single cycle; caller ensures the unit is idle.
  task automatic issue(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = code; op_a = a; op_b = b;
    tick();
    idle_inputs();
  endtask

  // Issues an op and watches a bounded window, counting Busy and Done cycles.
  task automatic run_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nb, output int nd);
    issue(code, a, b);
    nb = 0; nd = 0;
    for (int i = 0; i < 3 * M; i++) begin
      nb += int'(busy);
      nd += int'(done);
      tick();
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int nb, nd, dc;
    tick(); tick();
    reset = 1'b0; s_reset = 1'b0;
    chk_en = 1'b1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    // idle never stalls, even with a read request and an op offered
    read_req = 1'b1; start = 1'b1; op = 3'd0;
    #1 check("idle_stall", 64'(stall), 64'h0);
    idle_inputs();

    // 1: signed mult -2 * 3
    run_op(3'd3, 32'hFFFF_FFFE, 32'd3, nb, nd);
    check("mult_busy_cycles", 64'(nb), 64'd4);
    check("mult_done_pulses", 64'(nd), 64'd1);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    // 2: unsigned mult of the same operands
    run_op(3'd6, 32'hFFFF_FFFE, 32'd3, nb, nd);
    check("multu_hi", 64'(hi), 64'h2);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    // 3: madd carries into HI, msub borrows back
    issue(3'd2, 32'h0, 32'h0);
    issue(3'd1, 32'hFFFF_FFFF, 32'h0);
    check("mtlo_lo", 64'(lo), 64'hFFFF_FFFF);
    check("mthi_hi", 64'(hi), 64'h0);
    check("mtlo_not_busy", 64'(busy), 64'h0);
    run_op(3'd4, 32'd1, 32'd1, nb, nd);
    check("madd_hi", 64'(hi), 64'h1);
    check("madd_lo", 64'(lo), 64'h0);
    run_op(3'd5, 32'd1, 32'd1, nb, nd);
    check("msub_hi", 64'(hi), 64'h0);
    check("msub_lo", 64'(lo), 64'hFFFF_FFFF);

    // 4: read and second start while busy stall; the second op is dropped
    issue(3'd3, 32'd5, 32'd7);            // accepted at edge t
    tick();                                // after t+1
    start = 1'b1; op = 3'd3; op_a = 32'd9; op_b = 32'd9; read_req = 1'b1;
    #1 check("busy_stall_a", 64'(stall), 64'h1);
    tick();                                // after t+2
    check("busy_stall_b", 64'(stall), 64'h1);
    idle_inputs();
    tick();                                // after t+3
    check("lo_before_commit", 64'(lo), 64'hFFFF_FFFF);
    tick();                                // after t+4
    check("stall_mult_lo", 64'(lo), 64'd35);
    check("stall_mult_hi", 64'(hi), 64'd0);
    check("stall_mult_idle", 64'(busy), 64'h0);
    run_op(3'd3, 32'd9, 32'd9, nb, nd);
    check("represent_lo", 64'(lo), 64'd81);

    // 5: flush on the last busy cycle, then reset mid-operation
    issue(3'd2, 32'h11, 32'h0);
    issue(3'd1, 32'h11, 32'h0);
    issue(3'd3, 32'd5, 32'd7);
    tick(); tick(); tick();                // after t+3: counter at zero
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hi", 64'(hi), 64'h11);
    check("flush_lo", 64'(lo), 64'h11);
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_done", 64'(done), 64'h0);
    issue(3'd3, 32'd5, 32'd7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_hi", 64'(hi), 64'h0);
    check("midreset_lo", 64'(lo), 64'h0);
    check("midreset_busy", 64'(busy), 64'h0);
    dc = 0;
    for (int i = 0; i < 2 * M; i++) begin
      dc += int'(done);
      tick();
    end
    check("midreset_no_done", 64'(dc), 64'd0);
    check("midreset_lo_kept", 64'(lo), 64'h0);

    // 6: single-cycle 16-bit instance, back-to-back on the Done cycle
    s_start = 1'b1; s_op = 3'd3; s_a = 16'h8000; s_b = 16'h8000;
    tick();
    s_start = 1'b0;
    check("s_busy_one", 64'(s_busy), 64'h1);
    tick();
    check("s_first_hi", 64'(s_hi), 64'h4000);
    check("s_first_lo", 64'(s_lo), 64'h0000);
    check("s_first_done", 64'(s_done), 64'h1);
    check("s_first_idle", 64'(s_busy), 64'h0);
    s_start = 1'b1; s_a = 16'd2; s_b = 16'd3;
    tick();
    s_start = 1'b0;
    check("s_second_busy", 64'(s_busy), 64'h1);
    check("s_second_done_low", 64'(s_done), 64'h0);
    tick();
    check("s_second_hi", 64'(s_hi), 64'h0);
    check("s_second_lo", 64'(s_lo), 64'd6);
    check("s_second_done", 64'(s_done), 64'h1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 1) == 1);
      op       = 3'($urandom_range(0, 6));
      op_a     = pick();
      op_b     = pick();
      read_req = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
